fg_prog_sequencer: RTL and testbench

Sequences floating-gate programming of one FPAA island's indirect switch matrix. It accepts one command at a time over a valid/ready handshake, then drives the island's vertical/horizontal Vinj decoders, drain-select and FourTgate prog-switch controls. It times injection, tunnelling and read pulses in clock cycles and returns a completion status. It sits between the host programming interface and the island's programming mux.

---
 rtl/fg_prog_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_fg_prog_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer for one FPAA island's indirect switch matrix.
// Accepts one command at a time and times SETUP/PULSE/GAP/RDWIN/RELEASE phases in clock cycles.
module fg_prog_sequencer #(
    parameter int ROW_BITS = 6,
    parameter int COL_BITS = 6,
    parameter int PW_BITS  = 12,
    parameter int NP_BITS  = 8,
    parameter int SETTLE   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ROW_BITS-1:0] cmd_row,
    input  logic [COL_BITS-1:0] cmd_col,
    input  logic [PW_BITS-1:0]  cmd_pulse_w,
    input  logic [NP_BITS-1:0]  cmd_pulse_n,
    input  logic                abort,
    output logic [ROW_BITS-1:0] row_addr,
    output logic                row_en,
    output logic [COL_BITS-1:0] col_addr,
    output logic                col_en,
    output logic                drain_sel,
    output logic                prog_mode,
    output logic                vinj_pulse,
    output logic                tun_en,
    output logic                read_en,
    output logic                busy,
    output logic                done,
    output logic [1:0]          done_status
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int CNT_W = (PW_BITS > SET_W) ? PW_BITS : SET_W;

    localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [NP_BITS-1:0] NP_ONE    = NP_BITS'(1);

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_INJECT = 2'b01;
    localparam logic [1:0] OP_TUNNEL = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ABORT   = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_RDWIN,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t               state, nxt_state;
    logic [CNT_W-1:0]     cnt, nxt_cnt;
    logic [NP_BITS-1:0]   pn, nxt_pn;
    logic [1:0]           op_q, nxt_op;
    logic [1:0]           stat_q, nxt_stat;
    logic [ROW_BITS-1:0]  row_q, nxt_row;
    logic [COL_BITS-1:0]  col_q, nxt_col;
    logic [PW_BITS-1:0]   pw_q, nxt_pw;
    logic [CNT_W-1:0]     pw_ld;
    logic                 abort_act;

    logic [ROW_BITS-1:0]  nxt_row_addr;
    logic [COL_BITS-1:0]  nxt_col_addr;
    logic                 nxt_row_en, nxt_col_en, nxt_drain_sel, nxt_prog_mode;
    logic                 nxt_vinj, nxt_tun, nxt_read, nxt_done, sel_cmd;

    assign pw_ld = CNT_W'(pw_q) - CNT_ONE;

    assign abort_act = abort && (state == S_SETUP || state == S_PULSE ||
                                 state == S_GAP   || state == S_RDWIN);

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_pn    = pn;
        nxt_op    = op_q;
        nxt_stat  = stat_q;
        nxt_row   = row_q;
        nxt_col   = col_q;
        nxt_pw    = pw_q;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    nxt_op  = cmd_op;
                    nxt_row = cmd_row;
                    nxt_col = cmd_col;
                    nxt_pw  = cmd_pulse_w;
                    nxt_pn  = cmd_pulse_n;
                    if (cmd_op == OP_NOP) begin
                        nxt_state = S_DONE;
                        nxt_stat  = ST_OK;
                    end else if (cmd_pulse_w == '0) begin
                        nxt_state = S_DONE;
                        nxt_stat  = ST_ILLEGAL;
                    end else begin
                        nxt_state = S_SETUP;
                        nxt_cnt   = SETTLE_LD;
                        nxt_stat  = ST_OK;
                    end
                end
            end
            S_SETUP: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - CNT_ONE;
                end else if (op_q == OP_READ) begin
                    nxt_state = S_RDWIN;
                    nxt_cnt   = pw_ld;
                end else if (pn == '0) begin
                    nxt_state = S_RELEASE;
                    nxt_cnt   = SETTLE_LD;
                end else begin
                    nxt_state = S_PULSE;
                    nxt_cnt   = pw_ld;
                end
            end
            S_PULSE: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - CNT_ONE;
                end else begin
                    nxt_pn    = pn - NP_ONE;
                    nxt_state = (pn == NP_ONE) ? S_RELEASE : S_GAP;
                    nxt_cnt   = SETTLE_LD;
                end
            end
            S_GAP: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - CNT_ONE;
                end else begin
                    nxt_state = S_PULSE;
                    nxt_cnt   = pw_ld;
                end
            end
            S_RDWIN: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - CNT_ONE;
                end else begin
                    nxt_state = S_RELEASE;
                    nxt_cnt   = SETTLE_LD;
                end
            end
            S_RELEASE: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - CNT_ONE;
                end else begin
                    nxt_state = S_DONE;
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase

        // Abort outranks any phase expiry in the same cycle.
        if (abort_act) begin
            nxt_state = S_RELEASE;
            nxt_cnt   = SETTLE_LD;
            nxt_stat  = ST_ABORT;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        nxt_row_addr  = '0;
        nxt_col_addr  = '0;
        nxt_row_en    = 1'b0;
        nxt_col_en    = 1'b0;
        nxt_drain_sel = 1'b0;
        nxt_prog_mode = 1'b0;
        nxt_vinj      = 1'b0;
        nxt_tun       = 1'b0;
        nxt_read      = 1'b0;
        nxt_done      = 1'b0;
        sel_cmd       = (nxt_op == OP_INJECT) || (nxt_op == OP_READ);

        case (nxt_state)
            S_SETUP, S_PULSE, S_GAP, S_RDWIN: begin
                nxt_prog_mode = 1'b1;
                if (sel_cmd) begin
                    nxt_row_addr  = nxt_row;
                    nxt_col_addr  = nxt_col;
                    nxt_row_en    = 1'b1;
                    nxt_col_en    = 1'b1;
                    nxt_drain_sel = 1'b1;
                end
                if (nxt_state == S_PULSE) begin
                    nxt_vinj = (nxt_op == OP_INJECT);
                    nxt_tun  = (nxt_op == OP_TUNNEL);
                end
                if (nxt_state == S_RDWIN) begin
                    nxt_read = 1'b1;
                end
            end
            S_RELEASE: begin
                nxt_prog_mode = 1'b1;
            end
            S_DONE: begin
                nxt_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            pn          <= '0;
            op_q        <= OP_NOP;
            stat_q      <= ST_OK;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            row_addr    <= '0;
            col_addr    <= '0;
            row_en      <= 1'b0;
            col_en      <= 1'b0;
            drain_sel   <= 1'b0;
            prog_mode   <= 1'b0;
            vinj_pulse  <= 1'b0;
            tun_en      <= 1'b0;
            read_en     <= 1'b0;
            done        <= 1'b0;
            done_status <= ST_OK;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            pn          <= nxt_pn;
            op_q        <= nxt_op;
            stat_q      <= nxt_stat;
            cmd_ready   <= (nxt_state == S_IDLE);
            busy        <= (nxt_state != S_IDLE);
            row_addr    <= nxt_row_addr;
            col_addr    <= nxt_col_addr;
            row_en      <= nxt_row_en;
            col_en      <= nxt_col_en;
            drain_sel   <= nxt_drain_sel;
            prog_mode   <= nxt_prog_mode;
            vinj_pulse  <= nxt_vinj;
            tun_en      <= nxt_tun;
            read_en     <= nxt_read;
            done        <= nxt_done;
            if (nxt_state == S_DONE) begin
                done_status <= nxt_stat;
            end
        end
    end

    // Latched command operands carry no reset; they are always rewritten on accept.
    always_ff @(posedge clk) begin
        row_q <= nxt_row;
        col_q <= nxt_col;
        pw_q  <= nxt_pw;
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed bench for fg_prog_sequencer: per-cycle observation of each command against hand-computed timing.
module tb_fg_prog_sequencer;

    localparam int LIMIT = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_row;
    logic [5:0]  cmd_col;
    logic [11:0] cmd_pulse_w;
    logic [7:0]  cmd_pulse_n;
    logic        abort;
    logic [5:0]  row_addr;
    logic        row_en;
    logic [5:0]  col_addr;
    logic        col_en;
    logic        drain_sel;
    logic        prog_mode;
    logic        vinj_pulse;
    logic        tun_en;
    logic        read_en;
    logic        busy;
    logic        done;
    logic [1:0]  done_status;

    int n_checks = 0;
    int n_errors = 0;

    int r_done, r_status, r_vinj, r_vrise, r_tun, r_rd, r_sel, r_prog;
    int r_addr_bad, r_addr_nz, r_unsel, r_first, r_ready_bad;
    int dcount;

    fg_prog_sequencer #(
        .ROW_BITS(6), .COL_BITS(6), .PW_BITS(12), .NP_BITS(8), .SETTLE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_col(cmd_col),
        .cmd_pulse_w(cmd_pulse_w), .cmd_pulse_n(cmd_pulse_n), .abort(abort),
        .row_addr(row_addr), .row_en(row_en), .col_addr(col_addr), .col_en(col_en),
        .drain_sel(drain_sel), .prog_mode(prog_mode), .vinj_pulse(vinj_pulse),
        .tun_en(tun_en), .read_en(read_en), .busy(busy), .done(done),
        .done_status(done_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issues one command and observes every cycle until done; k is the cycle index after the accept edge.
    task automatic run_cmd(input logic [1:0] op, input int row, input int col,
                           input int w, input int n, input int abort_at);
        logic prev_v;
        r_done = 0; r_status = -1; r_vinj = 0; r_vrise = 0; r_tun = 0; r_rd = 0;
        r_sel = 0; r_prog = 0; r_addr_bad = 0; r_addr_nz = 0; r_unsel = 0;
        r_first = 0; r_ready_bad = 0;
        prev_v = 1'b0;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_row     = 6'(row);
        cmd_col     = 6'(col);
        cmd_pulse_w = 12'(w);
        cmd_pulse_n = 8'(n);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            if (vinj_pulse) r_vinj++;
            if (vinj_pulse && !prev_v) r_vrise++;
            prev_v = vinj_pulse;
            if (tun_en) r_tun++;
            if (read_en) r_rd++;
            if (prog_mode) r_prog++;
            if (cmd_ready) r_ready_bad++;
            if (row_en || col_en || drain_sel) r_sel++;
            if (row_en && (int'(row_addr) != row || int'(col_addr) != col)) r_addr_bad++;
            if (row_addr != '0 || col_addr != '0) r_addr_nz++;
            if ((vinj_pulse || read_en) && !(row_en && col_en && drain_sel)) r_unsel++;
            if ((vinj_pulse || tun_en || read_en) && r_first == 0) r_first = k;
            if (done) begin
                r_done   = k;
                r_status = int'(done_status);
                break;
            end
            abort = (k == abort_at);
        end
        abort = 1'b0;
        check("done_seen", int'(r_done != 0), 1);
    endtask

    task automatic check_ready_after(input string tag);
        @(negedge clk);
        check({tag, "_ready_after"}, int'(cmd_ready), 1);
        check({tag, "_done_after"}, int'(done), 0);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_row = 6'd1; cmd_col = 6'd1;
        cmd_pulse_w = 12'd5; cmd_pulse_n = 8'd1; abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_status", int'(done_status), 0);
        check("rst_prog", int'(prog_mode), 0);
        check("rst_sel", int'({row_en, col_en, drain_sel}), 0);
        check("rst_pulses", int'({vinj_pulse, tun_en, read_en}), 0);
        check("rst_addr", int'({row_addr, col_addr}), 0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;

        // INJECT row 5 col 9, W=10, n=3
        run_cmd(2'b01, 5, 9, 10, 3, 0);
        check("inj_done_cyc", r_done, 47);
        check("inj_status", r_status, 0);
        check("inj_vinj_cycles", r_vinj, 30);
        check("inj_vinj_pulses", r_vrise, 3);
        check("inj_first_pulse", r_first, 5);
        check("inj_sel_cycles", r_sel, 42);
        check("inj_addr_bad", r_addr_bad, 0);
        check("inj_unsel_pulse", r_unsel, 0);
        check("inj_prog_cycles", r_prog, 46);
        check("inj_tun", r_tun + r_rd, 0);
        check("inj_ready_busy", r_ready_bad, 0);
        check_ready_after("inj");

        // READ row 2 col 17, W=8 (pulse_n ignored)
        run_cmd(2'b11, 2, 17, 8, 5, 0);
        check("rd_done_cyc", r_done, 17);
        check("rd_status", r_status, 0);
        check("rd_cycles", r_rd, 8);
        check("rd_first", r_first, 5);
        check("rd_vinj", r_vinj + r_tun, 0);
        check("rd_sel_cycles", r_sel, 12);
        check("rd_addr_bad", r_addr_bad, 0);
        check("rd_unsel", r_unsel, 0);
        check_ready_after("rd");

        // TUNNEL W=20, n=1: decoders stay off
        run_cmd(2'b10, 3, 4, 20, 1, 0);
        check("tun_done_cyc", r_done, 29);
        check("tun_cycles", r_tun, 20);
        check("tun_sel", r_sel, 0);
        check("tun_addr_nz", r_addr_nz, 0);
        check("tun_vinj", r_vinj + r_rd, 0);
        check("tun_status", r_status, 0);

        // INJECT W=0 is illegal
        run_cmd(2'b01, 5, 9, 0, 3, 0);
        check("ill_done_cyc", r_done, 1);
        check("ill_status", r_status, 2);
        check("ill_outputs", r_vinj + r_tun + r_rd + r_sel + r_prog, 0);
        check_ready_after("ill");

        // INJECT n=0: setup and release only
        run_cmd(2'b01, 5, 9, 10, 0, 0);
        check("n0_done_cyc", r_done, 9);
        check("n0_status", r_status, 0);
        check("n0_vinj", r_vinj, 0);
        check("n0_prog_cycles", r_prog, 8);

        // NOP completes immediately
        run_cmd(2'b00, 1, 1, 7, 2, 0);
        check("nop_done_cyc", r_done, 1);
        check("nop_status", r_status, 0);
        check("nop_outputs", r_vinj + r_sel + r_prog, 0);

        // Abort in the 3rd cycle of the 2nd pulse (cycle 21)
        run_cmd(2'b01, 5, 9, 10, 3, 21);
        check("abt_done_cyc", r_done, 26);
        check("abt_status", r_status, 1);
        check("abt_vinj_cycles", r_vinj, 13);
        check("abt_vinj_pulses", r_vrise, 2);
        repeat (3) @(negedge clk);
        check("abt_status_held", int'(done_status), 1);
        check("abt_idle_done", int'(done), 0);

        // Reset asserted during the first GAP (cycles 15..18)
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_row = 6'd5; cmd_col = 6'd9;
        cmd_pulse_w = 12'd10; cmd_pulse_n = 8'd3;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (16) @(negedge clk);
        check("gap_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("gr_ready", int'(cmd_ready), 1);
        check("gr_busy", int'(busy), 0);
        check("gr_done", int'(done), 0);
        check("gr_status", int'(done_status), 0);
        check("gr_outputs", int'({row_en, col_en, drain_sel, prog_mode,
                                  vinj_pulse, tun_en, read_en}), 0);
        check("gr_addr", int'({row_addr, col_addr}), 0);
        cmd_valid = 1'b1; cmd_op = 2'b11;
        @(negedge clk);
        check("gr_cmd_ignored", int'(busy), 0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("gr_quiet", dcount, 0);
        run_cmd(2'b11, 2, 17, 8, 0, 0);
        check("gr_read_done_cyc", r_done, 17);
        check("gr_read_cycles", r_rd, 8);
        check("gr_read_status", r_status, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
